// File: rtl/vector_pkg.sv
// -----------------------------------------------------------------------------
// vector_pkg
// Shared fixed-point vector types for the surface pipeline.
//   fp       : signed Q8.24 scalar
//   vec3     : packed {x, y, z} of fp
//   FP_ONE   : 1.0 in Q8.24
//   rgb_t    : packed {r, g, b} pixel, 8 bits per channel
//   vec3_dot : Q8.24 dot product (full-precision sum, then rescaled)
// -----------------------------------------------------------------------------
package vector_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_ONE = 32'sh0100_0000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Products are Q16.48; summing before the shift keeps one rounding step.
  function automatic fp vec3_dot(input vec3 a, input vec3 b);
    logic signed [63:0] acc;
    acc = 64'(a.x) * 64'(b.x) + 64'(a.y) * 64'(b.y) + 64'(a.z) * 64'(b.z);
    return fp'(acc >>> 24);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous show-ahead FIFO of rgb_t pixels with occupancy counter.
//   clk, rst  : clock, asynchronous active-high reset (memory cleared too)
//   push_i    : write request; accepted when not full, or when full and a
//               pop happens in the same cycle
//   pop_i     : read request; ignored when empty
//   data_i    : pixel to write
//   data_o    : entry at the read pointer (valid whenever !empty_o)
//   full_o    : occupancy == DEPTH
//   empty_o   : occupancy == 0
// DEPTH must be a power of two, >= 2, so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module pixel_fifo
  import vector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  rgb_t data_i,
  output rgb_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rgb_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            wr_en;
  logic            rd_en;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: assign a default first so every path drives count_d (no latch).
    count_d = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && rd_en) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the memory is reset so the show-ahead output reads 0 out of reset;
  // this costs a reset net per bit, acceptable for a handful of entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/surface_shader.sv
// -----------------------------------------------------------------------------
// surface_shader
// Lambertian shading: dot(normal, light) -> clamped intensity -> RGB pixel,
// buffered in a small output FIFO toward a valid/ready pixel stream.
//   clk, rst            : clock, asynchronous active-high reset
//   valid_in            : input sample valid (push-only, no back-pressure)
//   hit_in              : ray hit the object; on a miss BG_COLOR is emitted
//   surfaceNormal       : unit normal, Q8.24 per component
//   surfaceLightVector  : unit vector toward the light, Q8.24
//   pixel_data          : FIFO head pixel {r,g,b}
//   pixel_valid         : FIFO not empty
//   pixel_ready         : downstream accepts pixel_data this cycle
//   overflow            : sticky, set when a pixel is dropped on a full FIFO
//   clear_overflow      : clears overflow (a same-cycle set wins)
// Pipeline: S1 dot product, S2 intensity, S3 colour, FIFO write on the next
// edge, so pixel_valid rises 3 edges after the sample edge.
// Build option: define SHADE_ROUND_EN to round-half-up the colour scaling
// instead of truncating.
// -----------------------------------------------------------------------------
module surface_shader
  import vector_pkg::*;
#(
  parameter fp           AMBIENT    = 32'h0019_999A,
  parameter logic [23:0] BASE_COLOR = 24'hFF8040,
  parameter logic [23:0] BG_COLOR   = 24'h000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic hit_in,
  input  vec3  surfaceNormal,
  input  vec3  surfaceLightVector,
  output rgb_t pixel_data,
  output logic pixel_valid,
  input  logic pixel_ready,
  output logic overflow,
  input  logic clear_overflow
);

  localparam logic [32:0] ONE_33 = 33'h0_0100_0000;

  // Scale one 8-bit channel by an intensity in [0, 1.0] (Q1.24).
  function automatic logic [7:0] shade_channel(input logic [7:0] base,
                                               input logic [24:0] inten);
    logic [33:0] prod;
    logic [33:0] scaled;
    prod = 34'(base) * 34'(inten);
`ifdef SHADE_ROUND_EN
    prod = prod + 34'h80_0000;
`endif
    scaled = prod >> 24;
    return (scaled > 34'd255) ? 8'hFF : scaled[7:0];
  endfunction

  // ---------------- S1: dot product ----------------
  logic v1_q;
  logic hit1_q;
  fp    dot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      hit1_q <= 1'b0;
      dot_q  <= '0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        dot_q  <= vec3_dot(surfaceNormal, surfaceLightVector);
        hit1_q <= hit_in;
      end
    end
  end

  // ---------------- S2: ambient + diffuse, clamped to 1.0 ----------------
  logic [31:0] diffuse;
  logic [32:0] sum_33;
  logic [24:0] intensity_d;
  logic [24:0] intensity_q;
  logic        v2_q;
  logic        hit2_q;

  // Back-facing light contributes nothing; the 33-bit sum cannot wrap.
  assign diffuse     = dot_q[31] ? 32'd0 : dot_q;
  assign sum_33      = {1'b0, AMBIENT} + {1'b0, diffuse};
  assign intensity_d = (sum_33 > ONE_33) ? 25'h100_0000 : sum_33[24:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q        <= 1'b0;
      hit2_q      <= 1'b0;
      intensity_q <= '0;
    end else begin
      v2_q        <= v1_q;
      hit2_q      <= hit1_q;
      intensity_q <= intensity_d;
    end
  end

  // ---------------- S3: colour ----------------
  rgb_t pix3_d;
  rgb_t pix3_q;
  logic v3_q;

  always_comb begin
    pix3_d = BG_COLOR;
    if (hit2_q) begin
      pix3_d.r = shade_channel(BASE_COLOR[23:16], intensity_q);
      pix3_d.g = shade_channel(BASE_COLOR[15:8],  intensity_q);
      pix3_d.b = shade_channel(BASE_COLOR[7:0],   intensity_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q   <= 1'b0;
      pix3_q <= '0;
    end else begin
      v3_q   <= v2_q;
      pix3_q <= pix3_d;
    end
  end

  // ---------------- Output FIFO and drop tracking ----------------
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic drop;
  logic overflow_q;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (v3_q),
    .pop_i   (pixel_ready),
    .data_i  (pix3_q),
    .data_o  (pixel_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pixel_valid = !fifo_empty;
  assign pop         = pixel_valid && pixel_ready;
  // Full with a simultaneous pop makes room, so only a pop-less full drops.
  assign drop        = v3_q && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_surface_shader.sv
// -----------------------------------------------------------------------------
// tb_surface_shader
// Self-checking bench for surface_shader. Two instances share stimulus: one
// with default parameters, one with BG_COLOR = 102030. A behavioural model
// (arithmetic shading, a 3-deep delay line and a queue for the FIFO) predicts
// every output after every clock edge.
// -----------------------------------------------------------------------------
module tb_surface_shader;
  import vector_pkg::*;

  localparam logic [31:0] AMB   = 32'h0019_999A;
  localparam logic [23:0] BASE  = 24'hFF8040;
  localparam logic [23:0] BG_B  = 24'h102030;
  localparam int          DEPTH = 4;
  localparam int          ONE   = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst;
  logic valid_in, hit_in, pixel_ready, clear_overflow;
  vec3  nrm, lgt;
  rgb_t pix_a, pix_b;
  logic pv_a, pv_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  surface_shader dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hit_in(hit_in),
    .surfaceNormal(nrm), .surfaceLightVector(lgt),
    .pixel_data(pix_a), .pixel_valid(pv_a), .pixel_ready(pixel_ready),
    .overflow(ovf_a), .clear_overflow(clear_overflow)
  );

  surface_shader #(.BG_COLOR(24'h102030)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hit_in(hit_in),
    .surfaceNormal(nrm), .surfaceLightVector(lgt),
    .pixel_data(pix_b), .pixel_valid(pv_b), .pixel_ready(pixel_ready),
    .overflow(ovf_b), .clear_overflow(clear_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          hit;
    logic [23:0] col;
  } ent_t;

  ent_t pipe [3];
  ent_t q [$];
  bit   m_ovf;

  function automatic logic [23:0] shade(input vec3 n, input vec3 l);
    longint      d, inten, p;
    logic [23:0] res;
    logic [7:0]  base_c;
    d = (longint'(n.x) * longint'(l.x) + longint'(n.y) * longint'(l.y) +
         longint'(n.z) * longint'(l.z)) >>> 24;
    d = longint'(int'(d));
    if (d < 0) d = 0;
    inten = longint'(AMB) + d;
    if (inten > ONE) inten = ONE;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      base_c = BASE[23 - 8*c -: 8];
      p = longint'(base_c) * inten;
`ifdef SHADE_ROUND_EN
      p = p + (longint'(1) << 23);
`endif
      p = p >> 24;
      if (p > 255) p = 255;
      res[23 - 8*c -: 8] = 8'(p);
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, hit: 1'b0, col: 24'h0};
    q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic compare();
    logic [23:0] exp_a, exp_b;
    check("valid_a", 32'(pv_a), 32'(q.size() > 0));
    check("valid_b", 32'(pv_b), 32'(q.size() > 0));
    check("ovf_a", 32'(ovf_a), 32'(m_ovf));
    check("ovf_b", 32'(ovf_b), 32'(m_ovf));
    if (q.size() > 0) begin
      exp_a = q[0].hit ? q[0].col : 24'h000000;
      exp_b = q[0].hit ? q[0].col : BG_B;
      check("data_a", {8'h0, pix_a}, {8'h0, exp_a});
      check("data_b", {8'h0, pix_b}, {8'h0, exp_b});
    end
  endtask

  // Called at a negedge with inputs driven: advance the model over the next
  // rising edge, let the DUT take that edge, then compare at the next negedge.
  task automatic tick();
    ent_t e_in, e_out;
    bit   do_pop, do_push, do_drop;
    e_in.v   = valid_in;
    e_in.hit = hit_in;
    e_in.col = shade(nrm, lgt);
    e_out    = pipe[2];
    do_pop   = (q.size() > 0) && pixel_ready;
    do_push  = e_out.v && ((q.size() < DEPTH) || do_pop);
    do_drop  = e_out.v && !do_push;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(e_out);
    if (do_drop) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e_in;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic vec3 mk(input int x, input int y, input int z);
    vec3 r;
    r.x = fp'(x);
    r.y = fp'(y);
    r.z = fp'(z);
    return r;
  endfunction

  function automatic int rcomp();
    int t;
    t = int'($urandom_range(0, 2 * ONE));
    return t - ONE;
  endfunction

  function automatic vec3 rvec();
    return mk(rcomp(), rcomp(), rcomp());
  endfunction

  task automatic drive(input bit v, input bit h, input vec3 n, input vec3 l,
                       input bit rdy, input bit clr);
    valid_in       = v;
    hit_in         = h;
    nrm            = n;
    lgt            = l;
    pixel_ready    = rdy;
    clear_overflow = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0), rdy, 1'b0);
      tick();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          drained;
    logic [23:0] exp_t2;

    rst = 1'b1;
    drive(1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0), 1'b0, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pv_a), 32'd0);
    check("rst_data", {8'h0, pix_a}, 32'h0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    rst = 1'b0;

    // Light along the normal: intensity clamps to 1.0, latency of 3 edges.
    drive(1'b1, 1'b1, mk(0, 0, ONE), mk(0, 0, ONE), 1'b1, 1'b0);
    tick();
    idle(2, 1'b1);
    check("t1_not_yet", 32'(pv_a), 32'd0);
    idle(1, 1'b1);
    check("t1_valid", 32'(pv_a), 32'd1);
    check("t1_data", {8'h0, pix_a}, 32'h00FF8040);
    idle(2, 1'b1);

    // Back-facing light: ambient only.
`ifdef SHADE_ROUND_EN
    exp_t2 = 24'h1A0D06;
`else
    exp_t2 = 24'h190C06;
`endif
    drive(1'b1, 1'b1, mk(ONE, 0, 0), mk(-ONE, 0, 0), 1'b1, 1'b0);
    tick();
    idle(3, 1'b1);
    check("t2_data", {8'h0, pix_a}, {8'h0, exp_t2});
    idle(2, 1'b1);

    // Miss: background colour on both instances.
    drive(1'b1, 1'b0, rvec(), rvec(), 1'b1, 1'b0);
    tick();
    idle(3, 1'b1);
    check("t3_bg_a", {8'h0, pix_a}, 32'h0);
    check("t3_bg_b", {8'h0, pix_b}, 32'h00102030);
    idle(2, 1'b1);

    // Six distinct hits with no ready: pixel 5 is dropped, 1-4 drain in order.
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b1, mk(ONE, 0, 0), mk(k * 32'h20_0000, 0, 0), 1'b0, 1'b0);
      tick();
    end
    idle(3, 1'b0);
    check("t4_ovf", 32'(ovf_a), 32'd1);
    drained = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0), 1'b1, 1'b0);
      if (pv_a) drained++;
      tick();
    end
    check("t4_drained", 32'(drained), 32'd4);
    check("t4_empty", 32'(pv_a), 32'd0);

    // Clear, fill to 4, then push and pop together while full.
    drive(1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0), 1'b0, 1'b1);
    tick();
    check("t5_cleared", 32'(ovf_a), 32'd0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, rvec(), rvec(), (i >= 7), 1'b0);
      tick();
    end
    check("t5_no_drop", 32'(ovf_a), 32'd0);
    check("t5_still_valid", 32'(pv_a), 32'd1);
    // Drop and clear in the same cycle: the set wins.
    drive(1'b1, 1'b1, rvec(), rvec(), 1'b0, 1'b1);
    tick();
    check("t5_set_wins", 32'(ovf_a), 32'd1);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Two queued, two in flight, then an asynchronous reset between edges.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, rvec(), rvec(), 1'b0, 1'b0);
      tick();
    end
    idle(1, 1'b0);
    check("t6_queued", 32'(pv_a), 32'd1);
    drive(1'b0, 1'b0, mk(0, 0, 0), mk(0, 0, 0), 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(pv_a), 32'd0);
    check("t6_async_data", {8'h0, pix_a}, 32'h0);
    check("t6_async_ovf", 32'(ovf_a), 32'd0);
    check("t6_async_data_b", {8'h0, pix_b}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(10, 1'b1);
    check("t6_no_stale_data", {8'h0, pix_a}, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), rvec(), rvec(),
            ($urandom_range(0, 4) < 3), ($urandom_range(0, 19) == 0));
      tick();
    end
    idle(8, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/surface_shader.md
# surface_shader

Lambertian shading stage that consumes the unit surface normal and unit surface-to-light vector produced by the surface-vector stage and turns them into a 24-bit RGB pixel. It sits between surface-vector generation and the frame-buffer writer. The upstream side is push-only (valid, no ready), so the block has a small output FIFO. That FIFO absorbs back-pressure from the downstream valid/ready pixel stream and flags any pixel it has to drop.

## Interface
- `AMBIENT`: default `32'h0019999A` (0.1). Ambient intensity, `fp` Q8.24.
- `BASE_COLOR`: default `24'hFF8040`. Object colour as {R,G,B}, 8 bits per channel.
- `BG_COLOR`: default `24'h000000`. Colour emitted on a miss.
- `FIFO_DEPTH`: default 4. Output FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-high
- `valid_in`  in  1  input sample valid, one sample per cycle, no back-pressure
- `hit_in`  in  1  ray hit the object
- `surfaceNormal`  in  `vec3`  unit normal, Q8.24 per component
- `surfaceLightVector`  in  `vec3`  unit vector toward the light, Q8.24
- `pixel_data`  out  24  FIFO head pixel {R,G,B}
- `pixel_valid`  out  1  FIFO not empty
- `pixel_ready`  in  1  downstream accepts `pixel_data` this cycle
- `overflow`  out  1  sticky; set when a pixel is dropped
- `clear_overflow`  in  1  clears `overflow`

## Operation
**S1**
- On `valid_in`, register `dot = vec3_dot(surfaceNormal, surfaceLightVector)` (Q8.24, signed) and `hit_in`.
- Without `valid_in`, the stage-1 valid bit clears.

**S2**
- `diffuse = (dot < 0) ? 0 : dot`.
- `intensity = min(AMBIENT + diffuse, FP_ONE)`, where `FP_ONE = 32'h01000000`.
- The addition is done in 33 bits and then saturated, so `intensity` always lies in [0, 1.0].

**S3**
- Per channel: `c = (BASE_c * intensity) >> 24`. The product is 8b × 25b = 33b unsigned; the result saturates to 255.
- If `hit == 0`, the pixel is `BG_COLOR` regardless of `dot`.

**FIFO**
- Push: S3 result is valid and the FIFO is not full.
- Pop: `pixel_valid && pixel_ready`.
- Full with a push and a pop in the same cycle: both happen and nothing is dropped.
- Full with a push and no pop: the pixel is dropped and `overflow` is set.
- Occupancy counter width is log2(`FIFO_DEPTH`)+1.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- `pixel_data` is the memory entry at the read pointer (show-ahead). Output order equals input order.
- `pixel_valid` and `pixel_data` are stable while `pixel_valid && !pixel_ready`.
- `overflow`: if a set and `clear_overflow` occur in the same cycle, set wins.

## Timing
- Reset values: `pixel_valid` 0, `pixel_data` 0, `overflow` 0. All pipeline valids, pointers and the counter are 0, and FIFO memory is cleared to 0.
- Reset is asynchronous: asserting `rst` mid-stream forces the outputs to these values immediately, and every in-flight pixel is discarded.
- `valid_in` at edge N: the S3 result is written at edge N+3, and `pixel_valid` = 1 after edge N+3. With an empty FIFO the latency is 3 cycles.
- Throughput is 1 pixel/cycle when `pixel_ready` is held at 1.
- A pop at edge M presents the next entry after edge M. `pixel_valid` falls after edge M if the FIFO becomes empty.
- `overflow` rises on the edge at which the drop occurs.

## Configuration
- `SHADE_ROUND_EN` defined: S3 computes `(BASE_c * intensity + 2^23) >> 24`, i.e. round-half-up, then saturates to 255.
- `SHADE_ROUND_EN` undefined: truncation, as specified in S3.
- Nothing else changes with the macro.

## Structure
- Package (`vector_pkg`) provides the existing `fp`, `vec3`, `vec3_dot` and `FP_ONE`. It also takes a new `rgb_t` packed struct {r,g,b}, 8 bits each, used for `pixel_data` and the FIFO entries.
- One sub-module: `pixel_fifo`, a parameterized synchronous FIFO with count, full, empty and show-ahead output. It is instantiated once.

## Test plan
All scenarios use default parameters unless stated.

1. Normal (0,0,1), light (0,0,1), hit=1, `pixel_ready`=1. Required: intensity clamps to 1.0; `pixel_data` = `FF8040` with `pixel_valid`=1 exactly 3 cycles after `valid_in`.
2. Normal (1,0,0), light (-1,0,0), hit=1. Required: `pixel_data` = `190C06` without the macro, `1A0D06` with `SHADE_ROUND_EN`.
3. Any vectors with hit=0. Required: `pixel_data` = `000000`. Rerun with `BG_COLOR`=`102030` and require `102030`.
4. `pixel_ready`=0 and 6 back-to-back hits with distinct colours. Required: `overflow`=1 after the 5th pixel. Then `pixel_ready`=1: exactly pixels 1–4 drain in order, then `pixel_valid`=0.
5. FIFO full, then `pixel_ready`=1 with a new pixel arriving the same cycle. Required: no drop, `overflow` stays 0, occupancy stays 4. Also drive `clear_overflow` in the same cycle as a drop and require `overflow`=1.
6. Assert `rst` asynchronously, between edges, with 2 pixels queued and 2 in flight. Required: `pixel_valid`, `pixel_data` and `overflow` go to 0 before the next edge. After release, no stale pixel ever appears.
